// File: rtl/la_capture_pkg.sv
// Shared types and defaults for the logic-analyser capture block.
// FSM state encoding, default widths, divider width and a state helper.
package la_capture_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;
   localparam int DIV_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } la_state_e;

   function automatic logic is_capturing(input la_state_e s);
      return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/la_capture_if.sv
// Bus between the host/trigger side (master) and la_capture (slave).
// Read handshake: rd_en is a request honoured only while done=1; each accepted
// request returns exactly one rd_valid strobe with rd_data on the next cycle.
interface la_capture_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   import la_capture_pkg::*;

   logic [DW-1:0] din;
   logic          trig_in;
   logic          arm;
   logic [AW-1:0] pre_cnt;
   logic          rd_en;
   logic          busy;
   logic          done;
   logic [AW-1:0] trig_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   la_state_e     state;

   modport master (
      output din, trig_in, arm, pre_cnt, rd_en,
      input  busy, done, trig_addr, rd_data, rd_valid, state
   );

   modport slave (
      input  din, trig_in, arm, pre_cnt, rd_en,
      output busy, done, trig_addr, rd_data, rd_valid, state
   );

endinterface

// File: rtl/la_capture_ram.sv
// Sample RAM: one write port and one registered read port, DEPTH x DW.
// Only the read register is reset; the array contents are don't-care.
module la_capture_ram #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!nrst)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/la_capture.sv
// Capture controller: pre-trigger fill, trigger wait, post-trigger fill, readback.
// Optional sample-rate divider enabled by defining LA_SAMPLE_DIV_EN.
module la_capture
   import la_capture_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic             clk,
   input  logic             nrst,
`ifdef LA_SAMPLE_DIV_EN
   input  logic [DIV_W-1:0] sample_div,
`endif
   la_capture_if.slave      bus
);

   la_state_e     state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] cnt;
   logic [AW-1:0] pre_lat;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] wr_ptr_inc;
   logic [AW-1:0] post_len;
   logic          busy;
   logic          done;
   logic          rd_valid;
   logic          sample;
   logic          wr_en;
   logic          rd_fire;

   assign wr_ptr_inc = wr_ptr + AW'(1);
   // DEPTH-1-pre in AW-bit arithmetic is simply the bitwise complement.
   assign post_len   = ~pre_lat;
   assign wr_en      = sample && is_capturing(state) && !bus.arm;
   assign rd_fire    = bus.rd_en && (state == ST_DONE) && !bus.arm;

`ifdef LA_SAMPLE_DIV_EN
   logic [DIV_W-1:0] div_cnt;

   // Strobe on the first cycle after arm, then every sample_div+1 cycles.
   always_ff @(posedge clk) begin
      if (!nrst)                                div_cnt <= '0;
      else if (bus.arm || div_cnt >= sample_div) div_cnt <= '0;
      else                                      div_cnt <= div_cnt + DIV_W'(1);
   end

   assign sample = (div_cnt == '0);
`else
   assign sample = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         pre_lat   <= '0;
         trig_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (bus.arm) begin
            wr_ptr  <= '0;
            pre_lat <= bus.pre_cnt;
            cnt     <= bus.pre_cnt;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= (bus.pre_cnt != '0) ? ST_PRE : ST_WAIT;
         end else begin
            case (state)
               ST_PRE: if (sample) begin
                  wr_ptr <= wr_ptr_inc;
                  cnt    <= cnt - AW'(1);
                  if (cnt == AW'(1)) state <= ST_WAIT;
               end
               ST_WAIT: if (sample) begin
                  wr_ptr <= wr_ptr_inc;
                  if (bus.trig_in) begin
                     trig_addr <= wr_ptr;
                     cnt       <= post_len;
                     if (post_len == '0) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        rd_ptr <= wr_ptr_inc;
                     end else begin
                        state <= ST_POST;
                     end
                  end
               end
               ST_POST: if (sample) begin
                  wr_ptr <= wr_ptr_inc;
                  cnt    <= cnt - AW'(1);
                  if (cnt == AW'(1)) begin
                     state  <= ST_DONE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     rd_ptr <= wr_ptr_inc;
                  end
               end
               ST_DONE: if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   la_capture_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .nrst  (nrst),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (bus.din),
      .re    (rd_fire),
      .raddr (rd_ptr),
      .rdata (bus.rd_data)
   );

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.trig_addr = trig_addr;
   assign bus.rd_valid  = rd_valid;
   assign bus.state     = state;

endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture: the reference model records the sampled stream and
// expects the readout to be the DEPTH samples starting pre_cnt before the trigger.
module tb_la_capture;
   import la_capture_pkg::*;

   localparam int DEPTH = 256;
   localparam int MAXC  = 4096;

   logic clk = 1'b0;
   logic nrst = 1'b0;
`ifdef LA_SAMPLE_DIV_EN
   logic [15:0] sample_div = '0;
`endif

   int   div_g = 0;
   int   errors = 0;
   int   checks = 0;
   bit   trig_sched [MAXC];
   logic [7:0] stream [$];
   logic [7:0] cap_buf [DEPTH];
   logic [7:0] exp_q [$];

   la_capture_if #(.AW(8), .DW(8)) bus ();

   la_capture #(.AW(8), .DW(8)) dut (
      .clk        (clk),
      .nrst       (nrst),
`ifdef LA_SAMPLE_DIV_EN
      .sample_div (sample_div),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic void clear_trig();
      for (int i = 0; i < MAXC; i++) trig_sched[i] = 1'b0;
   endfunction

   // Arm, then feed samples until done (or stop_at cycles), modelling the capture.
   task automatic do_capture(input int pre, input bit rnd, input int stop_at);
      int n, t, c, idx;
      bit got;
      stream.delete();
      n = 0; t = -1; c = 0; got = 1'b0;
      @(negedge clk);
      bus.arm = 1'b1; bus.pre_cnt = 8'(pre); bus.din = 8'ha5;
      bus.trig_in = trig_sched[0]; bus.rd_en = 1'b1;
`ifdef LA_SAMPLE_DIV_EN
      sample_div = 16'(div_g);
`endif
      @(negedge clk);
      bus.arm = 1'b0; bus.rd_en = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL arm_rd_prio: rd_valid=%b required 0", bus.rd_valid);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errors++; $display("FAIL arm_flags: busy=%b done=%b required 1/0", bus.busy, bus.done);
      end
      while (!got && c < MAXC) begin
         if (c == stop_at) begin
            bus.trig_in = 1'b0;
            return;
         end
         bus.din = rnd ? 8'($urandom_range(0, 255)) : 8'(c);
         bus.trig_in = trig_sched[c];
         if (c % (div_g + 1) == 0) begin
            stream.push_back(bus.din);
            if (t < 0 && n >= pre && trig_sched[c]) t = n;
            n++;
         end
         @(negedge clk);
         c++;
         if (bus.done === 1'b1) got = 1'b1;
      end
      bus.trig_in = 1'b0;
      checks++;
      if (!got || t < 0 || n != t + DEPTH - pre) begin
         errors++;
         $display("FAIL done_timing: done=%b after %0d samples, required after %0d", got, n, t + DEPTH - pre);
      end
      checks++;
      if (bus.trig_addr !== 8'(t)) begin
         errors++; $display("FAIL trig_addr: got %0d required %0d", bus.trig_addr, t % DEPTH);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL busy_at_done: busy=%b required 0", bus.busy);
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = t - pre + k;
         cap_buf[k] = (t >= 0 && idx < stream.size()) ? stream[idx] : 8'hxx;
      end
   endtask

   task automatic read_back(input int n, input bit gaps);
      int issued;
      bit en;
      logic [7:0] e;
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(cap_buf[k % DEPTH]);
      issued = 0;
      for (int cyc = 0; cyc < 8 * n + 16; cyc++) begin
         en = (issued < n) && (!gaps || $urandom_range(0, 3) != 0);
         bus.rd_en = en;
         if (en) issued++;
         @(negedge clk);
         checks++;
         if (bus.rd_valid !== en) begin
            errors++; $display("FAIL rd_valid: got %b required %b at read %0d", bus.rd_valid, en, issued);
         end
         if (en) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== e) begin
               errors++; $display("FAIL rd_data: read %0d got %0d required %0d", issued, bus.rd_data, e);
            end
         end
         if (!en && issued == n) break;
      end
      bus.rd_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL read_budget: %0d reads left, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; bus.rd_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_flags: busy=%b done=%b rd_valid=%b required 0", bus.busy, bus.done, bus.rd_valid);
      end
      checks++;
      if (bus.trig_addr !== 8'd0 || bus.rd_data !== 8'd0) begin
         errors++; $display("FAIL reset_data: trig_addr=%0d rd_data=%0d required 0", bus.trig_addr, bus.rd_data);
      end
      checks++;
      if (bus.state !== ST_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d required IDLE", bus.state);
      end
      nrst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.rd_en = i[0];
         @(negedge clk);
         checks++;
         if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL idle_rd: rd_valid=%b required 0", bus.rd_valid);
         end
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_pre16();
      clear_trig();
      trig_sched[100] = 1'b1;
      do_capture(16, 1'b0, -1);
      read_back(DEPTH, 1'b0);
   endtask

   task automatic test_pre0_held();
      for (int i = 0; i < MAXC; i++) trig_sched[i] = 1'b1;
      do_capture(0, 1'b0, -1);
      read_back(DEPTH + 2, 1'b0);
   endtask

   task automatic test_pre_ignore();
      clear_trig();
      trig_sched[5] = 1'b1; trig_sched[20] = 1'b1; trig_sched[50] = 1'b1;
      do_capture(32, 1'b0, -1);
      read_back(DEPTH, 1'b1);
   endtask

   task automatic test_rearm();
      clear_trig();
      trig_sched[100] = 1'b1;
      do_capture(16, 1'b0, 110);
      checks++;
      if (bus.done !== 1'b0 || bus.state !== ST_POST) begin
         errors++; $display("FAIL rearm_pre: done=%b state=%0d required 0/POST", bus.done, bus.state);
      end
      do_capture(16, 1'b0, -1);
      read_back(DEPTH, 1'b1);
   endtask

   task automatic test_reset_mid();
      clear_trig();
      do_capture(8, 1'b1, 30);
      checks++;
      if (bus.state !== ST_WAIT) begin
         errors++; $display("FAIL mid_state: got %0d required WAIT", bus.state);
      end
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== ST_IDLE) begin
         errors++; $display("FAIL mid_reset: busy=%b done=%b state=%0d required 0/0/IDLE", bus.busy, bus.done, bus.state);
      end
      bus.rd_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rd: rd_valid=%b required 0", bus.rd_valid);
         end
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_random();
      int pre;
      for (int it = 0; it < 6; it++) begin
         case (it)
            0:       pre = 255;
            1:       pre = 0;
            2:       pre = 1;
            default: pre = $urandom_range(0, 255);
         endcase
         for (int i = 0; i < MAXC; i++) trig_sched[i] = ($urandom_range(0, 15) == 0);
         do_capture(pre, 1'b1, -1);
         read_back(DEPTH, 1'b1);
      end
   endtask

`ifdef LA_SAMPLE_DIV_EN
   task automatic test_divider();
      clear_trig();
      trig_sched[81] = 1'b1;
      trig_sched[120] = 1'b1;
      div_g = 3;
      do_capture(4, 1'b0, -1);
      read_back(DEPTH, 1'b0);
      div_g = 0;
   endtask
`endif

   initial begin
      bus.din = '0; bus.trig_in = 1'b0; bus.arm = 1'b0; bus.pre_cnt = '0; bus.rd_en = 1'b0;
      test_reset();
      test_pre16();
      test_pre0_held();
      test_pre_ignore();
      test_rearm();
      test_reset_mid();
      test_random();
`ifdef LA_SAMPLE_DIV_EN
      test_divider();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
